// File: rtl/bist_runner_if.sv
// Host/BIST-facing signal bundle for the BIST run sequencer.
interface bist_runner_if #(
    parameter int unsigned CYC_W = 8
);
    logic             req_i;
    logic [1:0]       mode_i;
    logic             busy_o;
    logic             done_o;
    logic [1:0]       result_o;
    logic             fail_o;
    logic             timeout_o;
    logic [CYC_W-1:0] cycles_o;
    logic             bist_start_o;
    logic             bist_sel_o;
    logic             bist_success_i;
    logic [4:0]       bist_duration_i;

    modport master (
        input  req_i, mode_i, bist_success_i, bist_duration_i,
        output busy_o, done_o, result_o, fail_o, timeout_o, cycles_o,
               bist_start_o, bist_sel_o
    );

    modport slave (
        output req_i, mode_i, bist_success_i, bist_duration_i,
        input  busy_o, done_o, result_o, fail_o, timeout_o, cycles_o,
               bist_start_o, bist_sel_o
    );
endinterface

// File: rtl/bist_runner.sv
// Sequences one or two BIST pattern runs: launch, wait for the last vector,
// sample pass/fail, optionally chain pattern 1, then report with a cycle count.
module bist_runner #(
    parameter int unsigned VEC_LEN = 17,
    parameter int unsigned TIMEOUT = 32,
    parameter int unsigned CYC_W   = 8
) (
    input  logic           clk,
    input  logic           rst,
    bist_runner_if.master  bus
);
    localparam int unsigned WAIT_W  = $clog2(TIMEOUT);
    localparam int unsigned DUR_W   = 5;
    localparam logic [CYC_W-1:0] CYC_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_SAMPLE,
        S_REPORT
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          mode_q, mode_d;
    logic                idx_q, idx_d;
    logic [WAIT_W-1:0]   wcnt_q, wcnt_d;
    logic [1:0]          result_q, result_d;
    logic                fail_q, fail_d;
    logic                timeout_q, timeout_d;
    logic [CYC_W-1:0]    cycles_q, cycles_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                start_q, start_d;
    logic                sel_q, sel_d;
    logic                last_vec;

    assign last_vec = (bus.bist_duration_i == DUR_W'(VEC_LEN));

    // State register and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            mode_q    <= '0;
            idx_q     <= 1'b0;
            wcnt_q    <= '0;
            result_q  <= '0;
            fail_q    <= 1'b0;
            timeout_q <= 1'b0;
            cycles_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            start_q   <= 1'b0;
            sel_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            idx_q     <= idx_d;
            wcnt_q    <= wcnt_d;
            result_q  <= result_d;
            fail_q    <= fail_d;
            timeout_q <= timeout_d;
            cycles_q  <= cycles_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            start_q   <= start_d;
            sel_q     <= sel_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        idx_d     = idx_q;
        wcnt_d    = wcnt_q;
        result_d  = result_q;
        fail_d    = fail_q;
        timeout_d = timeout_q;
        cycles_d  = cycles_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.req_i) begin
                    mode_d    = bus.mode_i;
                    idx_d     = (bus.mode_i == 2'b01);
                    result_d  = '0;
                    fail_d    = 1'b0;
                    timeout_d = 1'b0;
                    cycles_d  = '0;
                    state_d   = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                wcnt_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                wcnt_d = wcnt_q + WAIT_W'(1);
                // First WAIT cycle may still show the previous run's final count
                if ((wcnt_q != '0) && last_vec) begin
                    state_d = S_SAMPLE;
                end else if (wcnt_q == WAIT_W'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    fail_d    = 1'b1;
                    state_d   = S_REPORT;
                end
            end
            S_SAMPLE: begin
                result_d[idx_q] = bus.bist_success_i;
                if (!bus.bist_success_i) begin
                    fail_d = 1'b1;
                end
                if (!idx_q && ((mode_q == 2'b10) ||
                               ((mode_q == 2'b11) && bus.bist_success_i))) begin
                    idx_d   = 1'b1;
                    state_d = S_LAUNCH;
                end else begin
                    state_d = S_REPORT;
                end
            end
            S_REPORT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if ((state_d != S_IDLE) && (cycles_d != CYC_MAX)) begin
            cycles_d = cycles_d + CYC_W'(1);
        end

        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_REPORT);
        start_d = (state_d == S_LAUNCH);
        sel_d   = idx_d;
    end

    assign bus.busy_o       = busy_q;
    assign bus.done_o       = done_q;
    assign bus.result_o     = result_q;
    assign bus.fail_o       = fail_q;
    assign bus.timeout_o    = timeout_q;
    assign bus.cycles_o     = cycles_q;
    assign bus.bist_start_o = start_q;
    assign bus.bist_sel_o   = sel_q;

endmodule

// File: tb/tb_bist_runner.sv
// Self-checking bench for bist_runner with a behavioural BIST counter model.
module tb_bist_runner;
    localparam int unsigned VEC_LEN = 17;
    localparam int unsigned TIMEOUT = 32;
    localparam int unsigned CYC_W   = 8;
    localparam int          CYC_SAT = (1 << CYC_W) - 1;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    bist_runner_if #(.CYC_W(CYC_W)) bus ();

    bist_runner #(
        .VEC_LEN (VEC_LEN),
        .TIMEOUT (TIMEOUT),
        .CYC_W   (CYC_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One run: req in cycle 0, BIST counter lags 'lag' cycles, 'stuck' ties duration to 5
    task automatic run_case(input string nm, input logic [1:0] mode, input logic p0, input logic p1,
                            input bit stuck, input bit stale, input int lag, input bit hold);
        int   exp_cyc[$];
        int   exp_sel[$];
        int   got_cyc[$];
        int   got_sel[$];
        int   pats[$];
        logic pass_a [2];
        int   t, e_done, e_cycles, got_done, done_cnt, last_start, k, d, n;
        logic [1:0] e_res;
        logic e_fail, e_to, cur_sel;
        logic [1:0] g_res;
        logic g_fail, g_to, g_busy;
        logic [CYC_W-1:0] g_cyc;

        pass_a[0] = p0;
        pass_a[1] = p1;
        if (mode == 2'b00) pats.push_back(0);
        else if (mode == 2'b01) pats.push_back(1);
        else begin pats.push_back(0); pats.push_back(1); end

        t = 1; e_res = '0; e_fail = 1'b0; e_to = 1'b0;
        for (int i = 0; i < pats.size(); i++) begin
            exp_cyc.push_back(t);
            exp_sel.push_back(pats[i]);
            if (stuck || (VEC_LEN + lag > TIMEOUT - 1)) begin
                e_to = 1'b1; e_fail = 1'b1;
                t = t + 1 + TIMEOUT;
                break;
            end
            e_res[pats[i]] = pass_a[pats[i]];
            if (!pass_a[pats[i]]) e_fail = 1'b1;
            t = t + 1 + (VEC_LEN + lag + 1) + 1;
            if ((mode == 2'b11) && !pass_a[pats[i]]) break;
        end
        e_done   = t;
        e_cycles = (e_done > CYC_SAT) ? CYC_SAT : e_done;

        bus.req_i           = 1'b1;
        bus.mode_i          = mode;
        bus.bist_duration_i = stuck ? 5'd5 : (stale ? 5'd17 : 5'd0);
        bus.bist_success_i  = 1'b0;
        last_start = -1; got_done = -1; done_cnt = 0; cur_sel = 1'b0;
        g_res = '0; g_fail = 1'b0; g_to = 1'b0; g_cyc = '0; g_busy = 1'b0;

        for (int c = 1; c <= 150; c++) begin
            @(posedge clk); #1;
            if (c == 1) chk({nm, "_busy_run"}, 32'(bus.busy_o), 32'd1);
            if (bus.bist_start_o) begin
                got_cyc.push_back(c);
                got_sel.push_back(int'(bus.bist_sel_o));
                last_start = c;
                cur_sel = bus.bist_sel_o;
            end
            if (bus.done_o) begin
                done_cnt++;
                if (got_done < 0) begin
                    got_done = c;
                    g_res = bus.result_o; g_fail = bus.fail_o; g_to = bus.timeout_o;
                    g_cyc = bus.cycles_o; g_busy = bus.busy_o;
                end
            end
            if ((got_done >= 0) && (c == got_done + 1)) begin
                chk({nm, "_idle_busy"},   32'(bus.busy_o),       32'd0);
                chk({nm, "_idle_result"}, 32'(bus.result_o),     32'(e_res));
                chk({nm, "_idle_fail"},   32'(bus.fail_o),       32'(e_fail));
                chk({nm, "_idle_cycles"}, 32'(bus.cycles_o),     32'(e_cycles));
                chk({nm, "_idle_start"},  32'(bus.bist_start_o), 32'd0);
                break;
            end
            bus.req_i = (hold && (got_done < 0)) ? 1'b1 : 1'b0;
            if (stuck) begin
                bus.bist_duration_i = 5'd5;
            end else if ((last_start >= 0) && (c > last_start)) begin
                k = c - last_start - 1;
                d = (k < lag) ? 0 : (((k - lag) > VEC_LEN) ? VEC_LEN : (k - lag));
                if (stale && (k == 0)) d = VEC_LEN;
                bus.bist_duration_i = 5'(d);
            end
            if (last_start >= 0) bus.bist_success_i = pass_a[cur_sel];
        end
        bus.req_i = 1'b0;

        chk({nm, "_done_cycle"},   32'(got_done),     32'(e_done));
        chk({nm, "_done_width"},   32'(done_cnt),     32'd1);
        chk({nm, "_done_busy"},    32'(g_busy),       32'd1);
        chk({nm, "_result"},       32'(g_res),        32'(e_res));
        chk({nm, "_fail"},         32'(g_fail),       32'(e_fail));
        chk({nm, "_timeout"},      32'(g_to),         32'(e_to));
        chk({nm, "_cycles"},       32'(g_cyc),        32'(e_cycles));
        chk({nm, "_start_count"},  32'(got_cyc.size()), 32'(exp_cyc.size()));
        n = (got_cyc.size() < exp_cyc.size()) ? got_cyc.size() : exp_cyc.size();
        for (int i = 0; i < n; i++) begin
            chk({nm, "_start_cycle"}, 32'(got_cyc[i]), 32'(exp_cyc[i]));
            chk({nm, "_start_sel"},   32'(got_sel[i]), 32'(exp_sel[i]));
        end
    endtask

    initial begin
        int aborted_done;
        logic [1:0] rm;
        rst = 1'b1;
        bus.req_i = 1'b1;
        bus.mode_i = 2'b00;
        bus.bist_success_i = 1'b0;
        bus.bist_duration_i = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", 32'({bus.busy_o, bus.done_o, bus.result_o, bus.fail_o, bus.timeout_o,
                               bus.cycles_o, bus.bist_start_o, bus.bist_sel_o}), 32'd0);
        rst = 1'b0;
        bus.req_i = 1'b0;
        @(posedge clk); #1;
        chk("idle_after_reset", 32'({bus.busy_o, bus.bist_start_o}), 32'd0);

        run_case("m00_pass",      2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 0,  1'b0);
        run_case("m10_p1fail",    2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 0,  1'b0);
        run_case("m11_p0fail",    2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 0,  1'b0);
        run_case("m01_stuck",     2'b01, 1'b1, 1'b1, 1'b1, 1'b0, 0,  1'b0);
        run_case("m00_stale",     2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 0,  1'b0);
        run_case("m11_both_hold", 2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 0,  1'b1);
        run_case("m01_lag_edge",  2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 14, 1'b0);
        run_case("m00_lag_to",    2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 15, 1'b0);

        // Abort a run with reset while req stays high, then restart from IDLE
        aborted_done = 0;
        bus.req_i = 1'b1;
        bus.mode_i = 2'b10;
        bus.bist_duration_i = 5'd0;
        bus.bist_success_i = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (bus.done_o) aborted_done++;
            if (c == 10) rst = 1'b1;
        end
        @(posedge clk); #1;
        chk("abort_outs", 32'({bus.busy_o, bus.done_o, bus.result_o, bus.fail_o, bus.timeout_o,
                               bus.cycles_o, bus.bist_start_o, bus.bist_sel_o}), 32'd0);
        chk("abort_no_done", 32'(aborted_done), 32'd0);
        rst = 1'b0;
        run_case("post_reset", 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b1);

        for (int r = 0; r < 8; r++) begin
            rm = 2'($urandom_range(0, 3));
            run_case($sformatf("rnd%0d", r), rm, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
